// File: rtl/bce.sv
// Branch condition evaluator: decides taken/not-taken for a 4-bit branch
// function over two operands, combinationally and as a registered copy with valid.
module bce #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [3:0]   bf,
   output logic         bcres,
   output logic         illegal,
   output logic         bcres_q,
   output logic         illegal_q,
   output logic         out_valid
);

   typedef enum logic [3:0] {
      BF_BLTZ  = 4'b0000,
      BF_BGEZ  = 4'b0001,
      BF_BEQ   = 4'b0010,
      BF_BNE   = 4'b0011,
      BF_BLEZ  = 4'b0100,
      BF_BGTZ  = 4'b0101,
      BF_BLT   = 4'b0110,
      BF_BGE   = 4'b0111,
      BF_BLTU  = 4'b1000,
      BF_BGEU  = 4'b1001,
      BF_ALWAYS = 4'b1010,
      BF_NEVER = 4'b1011
   } bf_e;

   logic w_a_neg;
   logic w_a_zero;
   logic w_eq;
   logic w_lt_u;
   logic w_lt_s;

   assign w_a_neg  = a[W-1];
   assign w_a_zero = (a == '0);
   assign w_eq     = (a == b);
   assign w_lt_u   = (a < b);
   // Differing signs decide the signed order outright; equal signs reduce to
   // the unsigned compare, so no subtractor overflow can corrupt the result.
   assign w_lt_s   = (a[W-1] != b[W-1]) ? a[W-1] : w_lt_u;

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      bcres   = 1'b0;
      illegal = 1'b0;
      case (bf)
         BF_BLTZ:   bcres = w_a_neg;
         BF_BGEZ:   bcres = ~w_a_neg;
         BF_BEQ:    bcres = w_eq;
         BF_BNE:    bcres = ~w_eq;
         BF_BLEZ:   bcres = w_a_neg | w_a_zero;
         BF_BGTZ:   bcres = ~(w_a_neg | w_a_zero);
         BF_BLT:    bcres = w_lt_s;
         BF_BGE:    bcres = ~w_lt_s;
         BF_BLTU:   bcres = w_lt_u;
         BF_BGEU:   bcres = ~w_lt_u;
         BF_ALWAYS: bcres = 1'b1;
         BF_NEVER:  bcres = 1'b0;
         default:   illegal = 1'b1;
      endcase
   end

   logic r_bcres_q;
   logic r_illegal_q;
   logic r_out_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_bcres_q   <= 1'b0;
         r_illegal_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_bcres_q   <= bcres;
            r_illegal_q <= illegal;
         end
      end
   end

   assign bcres_q   = r_bcres_q;
   assign illegal_q = r_illegal_q;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_bce.sv
// Directed bench for bce: combinational decode checks plus a scoreboard queue
// that tracks the registered decision through valid, hold and reset.
module tb_bce;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  bf;
   logic        bcres;
   logic        illegal;
   logic        bcres_q;
   logic        illegal_q;
   logic        out_valid;

   bce dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .bf        (bf),
      .bcres     (bcres),
      .illegal   (illegal),
      .bcres_q   (bcres_q),
      .illegal_q (illegal_q),
      .out_valid (out_valid)
   );

   typedef struct packed {
      logic bcres;
      logic illegal;
   } exp_t;

   exp_t sb_q[$];
   exp_t last_q;
   logic exp_valid;
   int   n_checks;
   int   n_pass;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input logic obs, input logic exp, input string tag);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
   endtask

   // Independent reference for the random sweep, written with native operators.
   function automatic logic model(input logic [31:0] x, input logic [31:0] y,
                                  input logic [3:0] f);
      case (f)
         4'd0:  return $signed(x) < 0;
         4'd1:  return $signed(x) >= 0;
         4'd2:  return x == y;
         4'd3:  return x != y;
         4'd4:  return $signed(x) <= 0;
         4'd5:  return $signed(x) > 0;
         4'd6:  return $signed(x) < $signed(y);
         4'd7:  return $signed(x) >= $signed(y);
         4'd8:  return x < y;
         4'd9:  return x >= y;
         4'd10: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check_regs(input string tag);
      check(out_valid, exp_valid, {tag, " out_valid"});
      if (exp_valid) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            $error("FAIL %s scoreboard: observed=empty expected=entry", tag);
         end else begin
            last_q = sb_q.pop_front();
         end
      end
      check(bcres_q, last_q.bcres, {tag, " bcres_q"});
      check(illegal_q, last_q.illegal, {tag, " illegal_q"});
   endtask

   task automatic step(input logic v, input logic [31:0] ta, input logic [31:0] tb,
                       input logic [3:0] tf, input logic eb, input logic ei,
                       input string tag);
      @(negedge clk);
      in_valid = v;
      a        = ta;
      b        = tb;
      bf       = tf;
      #1;
      check(bcres, eb, {tag, " bcres"});
      check(illegal, ei, {tag, " illegal"});
      if (v) sb_q.push_back('{bcres: eb, illegal: ei});
      exp_valid = v;
      @(posedge clk);
      #1;
      check_regs(tag);
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      last_q    = '0;
      exp_valid = 1'b0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      bf        = 4'b1011;
      #3;
      check(out_valid, 1'b0, "reset out_valid");
      check(bcres_q, 1'b0, "reset bcres_q");
      check(illegal_q, 1'b0, "reset illegal_q");
      @(negedge clk);
      rst_n = 1'b1;

      step(1'b1, 32'hFFFF_FFFF, 32'd0, 4'b0000, 1'b1, 1'b0, "bltz -1");
      step(1'b1, 32'd0, 32'd0, 4'b0001, 1'b1, 1'b0, "bgez 0");
      step(1'b1, 32'hFFFF_FFFF, 32'd0, 4'b0001, 1'b0, 1'b0, "bgez -1");
      step(1'b1, 32'd42, 32'd42, 4'b0010, 1'b1, 1'b0, "beq 42/42");
      step(1'b1, 32'd10, 32'd5, 4'b0011, 1'b1, 1'b0, "bne 10/5");
      step(1'b1, 32'd42, 32'd42, 4'b0011, 1'b0, 1'b0, "bne 42/42");
      step(1'b1, 32'hFFFF_FFFC, 32'd0, 4'b0100, 1'b1, 1'b0, "blez -4");
      step(1'b1, 32'd7, 32'd0, 4'b0101, 1'b1, 1'b0, "bgtz 7");
      step(1'b1, 32'd0, 32'd0, 4'b0100, 1'b1, 1'b0, "blez 0");
      step(1'b1, 32'd0, 32'd0, 4'b0101, 1'b0, 1'b0, "bgtz 0");
      step(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 4'b0110, 1'b1, 1'b0, "blt min/max");
      step(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 4'b1000, 1'b0, 1'b0, "bltu min/max");
      step(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 4'b0111, 1'b1, 1'b0, "bge max/min");
      step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0111, 1'b1, 1'b0, "bge -1/-1");
      step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1001, 1'b1, 1'b0, "bgeu ff/ff");
      step(1'b1, 32'd1, 32'hFFFF_FFFF, 4'b1001, 1'b0, 1'b0, "bgeu 1/ff");
      step(1'b1, 32'd3, 32'd9, 4'b1010, 1'b1, 1'b0, "always");
      step(1'b1, 32'd3, 32'd3, 4'b1011, 1'b0, 1'b0, "never");
      for (int f = 12; f < 16; f++) begin
         step(1'b1, 32'd0, 32'd0, 4'(f), 1'b0, 1'b1, $sformatf("reserved %0d", f));
      end

      // Valid then idle: registered decision must hold while in_valid is low.
      step(1'b1, 32'd42, 32'd42, 4'b0010, 1'b1, 1'b0, "pipe beq");
      step(1'b0, 32'd1, 32'd2, 4'b0010, 1'b0, 1'b0, "pipe idle");
      step(1'b0, 32'd0, 32'd0, 4'b1100, 1'b0, 1'b1, "pipe idle rsvd");

      for (int i = 0; i < 24; i++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         logic [3:0]  rf;
         ra = $urandom();
         rb = (i % 4 == 0) ? ra : $urandom();
         if (i % 6 == 1) ra[31] = ~rb[31];
         rf = 4'($urandom_range(0, 11));
         step(1'b1, ra, rb, rf, model(ra, rb, rf), 1'b0, $sformatf("rand %0d", i));
      end

      // Asynchronous reset between edges with a result pending.
      step(1'b1, 32'd42, 32'd42, 4'b0010, 1'b1, 1'b0, "pre-reset beq");
      @(negedge clk);
      in_valid = 1'b1;
      a        = 32'd5;
      b        = 32'd5;
      bf       = 4'b0010;
      #2;
      rst_n = 1'b0;
      #1;
      check(out_valid, 1'b0, "async rst out_valid");
      check(bcres_q, 1'b0, "async rst bcres_q");
      check(illegal_q, 1'b0, "async rst illegal_q");
      check(bcres, 1'b1, "async rst comb bcres");
      @(posedge clk);
      #1;
      check(out_valid, 1'b0, "held rst out_valid");
      check(bcres_q, 1'b0, "held rst bcres_q");
      sb_q.delete();
      last_q    = '0;
      exp_valid = 1'b0;
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      step(1'b0, 32'd0, 32'd0, 4'b0010, 1'b1, 1'b0, "post-reset idle");
      step(1'b1, 32'd0, 32'd0, 4'b1111, 1'b0, 1'b1, "post-reset rsvd");

      @(negedge clk);
      in_valid = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bce.md
Name: bce

Overview:
- Branch condition evaluator for the integer pipeline's execute stage.
- Compares two 32-bit operands under a 4-bit branch-function code and produces the taken/not-taken decision.
- The decision is available combinationally for same-cycle redirect, and as a registered copy with valid for the next stage.
- Codes 0000-0101 follow the classic MIPS branch set: BLTZ, BGEZ, BEQ, BNE, BLEZ, BGTZ.

Parameters:
- W, 32, operand width in bits; two's complement for signed codes.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies a/b/bf for registration this cycle.
- a  input  W  first operand, rs.
- b  input  W  second operand, rt; ignored by single-operand codes.
- bf  input  4  branch function code.
- bcres  output  1  combinational branch decision for current a/b/bf.
- illegal  output  1  combinational; high when bf is a reserved code.
- bcres_q  output  1  registered decision.
- illegal_q  output  1  registered illegal flag.
- out_valid  output  1  registered in_valid.

Behaviour:
- bf decode, signed unless noted:
  - 0000 BLTZ: a<0, i.e. a[W-1].
  - 0001 BGEZ: a>=0.
  - 0010 BEQ: a==b.
  - 0011 BNE: a!=b.
  - 0100 BLEZ: a<=0, i.e. sign bit or a==0.
  - 0101 BGTZ: a>0.
  - 0110 BLT: a<b signed.
  - 0111 BGE: a>=b signed.
  - 1000 BLTU: a<b unsigned.
  - 1001 BGEU: a>=b unsigned.
  - 1010: always taken, 1.
  - 1011: never taken, 0.
  - 1100-1111: reserved; bcres=0, illegal=1.
- illegal=0 for all defined codes.
- bcres and illegal are purely combinational from a, b, bf; no dependence on clk, rst_n or in_valid. An X-free input produces an X-free output.
- Signed compare: exact for all pairs, including a=-2^(W-1) and b=2^(W-1)-1. No overflow error from subtract-based implementations; sign-correct compare is required.
- Registered path, on rising clk:
  - out_valid <= in_valid.
  - When in_valid=1: bcres_q <= bcres and illegal_q <= illegal.
  - When in_valid=0: bcres_q and illegal_q hold their values.
- Latency: 1 cycle from in_valid sample to out_valid. No backpressure; one result per cycle, back-to-back allowed.
- Reset: rst_n low asynchronously forces out_valid=0, bcres_q=0, illegal_q=0 immediately, regardless of clk.
  - Combinational outputs are unaffected by reset.
  - Release is synchronised externally; the first capture occurs on the first rising edge with rst_n high.
- Reset asserted mid-stream discards any pending result; no partial output.

Test Plan:
- BLTZ/BGEZ: a=-1,b=0,bf=0000 -> bcres=1. Then a=0,bf=0001 -> bcres=1. Also a=-1,bf=0001 -> 0.
- BEQ/BNE: a=42,b=42,bf=0010 -> 1. Then a=10,b=5,bf=0011 -> 1. Also a=42,b=42,bf=0011 -> 0.
- BLEZ/BGTZ: a=-4,bf=0100 -> 1. a=7,bf=0101 -> 1. a=0 with bf=0100 -> 1 and bf=0101 -> 0.
- Signed/unsigned extremes: a=32'h8000_0000, b=32'h7FFF_FFFF:
  - bf=0110 -> 1; bf=1000 -> 0.
  - a=b=32'hFFFF_FFFF: bf=0111 -> 1 and bf=1001 -> 1.
- Reserved and fixed codes: bf=1010 -> bcres=1; bf=1011 -> 0; bf=1100..1111 -> bcres=0, illegal=1.
- Pipeline and reset:
  - in_valid=1 with BEQ 42/42 -> next cycle out_valid=1, bcres_q=1.
  - in_valid=0 -> out_valid=0, bcres_q holds 1.
  - Drop rst_n between edges -> all registered outputs 0 immediately.
